freq_meter: RTL

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// freq_meter
//   Counts rising edges of an asynchronous input over a fixed gate window of
//   GATE_CYCLES clock cycles and reports the count.
//   Each measurement runs IDLE -> ARM -> GATE -> DONE.
//   The result registers update on the clock edge that ends DONE.
//
// Parameters
//   GATE_CYCLES  gate window length in clk cycles (>= 1)
//   CNT_WIDTH    width of the edge-count result
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous active-high reset
//   sig_i         signal under measurement (asynchronous to clk)
//   start_i       request a measurement (only looked at in IDLE)
//   continuous_i  re-arm after each result (looked at in DONE)
//   busy_o        measurement in progress (ARM, GATE or DONE)
//   freq_o        rising-edge count of the last completed window
//   valid_o       one-cycle pulse when freq_o/ovf_o take a new value
//   ovf_o         last completed window's count saturated
module freq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sig_i,
    input  logic                 start_i,
    input  logic                 continuous_i,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] freq_o,
    output logic                 valid_o,
    output logic                 ovf_o
);

    // Sized so that GATE_CYCLES itself is representable; the counter never wraps.
    localparam int GW = $clog2(GATE_CYCLES + 1);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [GW-1:0]        GATE_LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic                 sync1;
    logic                 sync2;
    logic                 history;
    logic                 edge_pulse;
    logic [CNT_WIDTH-1:0] edge_cnt;
    logic                 ovf_flag;
    logic [GW-1:0]        gate_cnt;
    logic                 gate_done;

    // Two-flop synchronizer, then a history flop for rising-edge detection.
    // A high input at reset release counts as an edge because all three flops
    // reset to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            history <= 1'b0;
        end else begin
            sync1   <= sig_i;
            sync2   <= sync1;
            history <= sync2;
        end
    end

    assign edge_pulse = sync2 & ~history;
    assign gate_done  = (gate_cnt == GATE_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and busy decode
    always_comb begin
        state_next = state;
        busy_o     = 1'b1;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                state_next = GATE;
            end
            GATE: begin
                if (gate_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = continuous_i ? ARM : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath.
    // ARM clears the window counters.
    // GATE counts cycles and edge pulses, saturating the edge count and
    // flagging any edge that arrives while it is saturated.
    // DONE publishes the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            gate_cnt <= '0;
            freq_o   <= '0;
            ovf_o    <= 1'b0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                ARM: begin
                    edge_cnt <= '0;
                    ovf_flag <= 1'b0;
                    gate_cnt <= '0;
                end
                GATE: begin
                    gate_cnt <= gate_cnt + 1'b1;
                    if (edge_pulse) begin
                        if (edge_cnt == CNT_MAX) begin
                            ovf_flag <= 1'b1;
                        end else begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    freq_o  <= edge_cnt;
                    ovf_o   <= ovf_flag;
                    valid_o <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
